// File: rtl/rc4_encrypt_core.sv
// rc4_encrypt_core
//
// Single-core RC4 encryptor. It runs the key-scheduling pass over an external
// 256x8 S RAM and then the keystream generator. Each keystream byte is XORed
// with one plaintext byte to form one ciphertext byte. MSG_LEN bytes are
// produced per run.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               level input; a run begins on its rising edge (IDLE only)
//   secret_key[23:0]    key bytes {k0, k1, k2}, latched at start
//   s_address/s_data/s_wren/s_q
//                       external S RAM port; s_q is valid the cycle after
//                       the address is applied
//   pt_data/pt_valid/pt_ready
//                       plaintext input handshake
//   ct_data/ct_index/ct_valid/ct_ready
//                       ciphertext output handshake with byte index
//   busy                run in progress
//   done                one-cycle pulse after the last ciphertext handshake
module rc4_encrypt_core #(
  parameter int MSG_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  input  logic [7:0]  s_q,
  input  logic [7:0]  pt_data,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic [7:0]  ct_data,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic [7:0]  ct_index,
  output logic        busy,
  output logic        done
);

  typedef enum logic [4:0] {
    S_IDLE, S_INIT,
    K_RD_I, K_WT_I, K_RD_J, K_WT_J, K_WR_I, K_WR_J,
    P_INC, P_WT_I, P_RD_J, P_WT_J, P_WR_I, P_WR_J, P_RD_F, P_WT_F, P_PT, P_OUT,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t      state;
  logic        start_q;
  logic [23:0] key;
  logic [7:0]  i, j, k;
  logic [7:0]  si, sj;
  logic [1:0]  key_sel;   // i mod 3, tracked incrementally

  logic [7:0]  key_byte;
  logic [7:0]  j_ksa;
  logic [7:0]  j_prga;

  always_comb begin
    key_byte = key[23:16];
    case (key_sel)
      2'd1:    key_byte = key[15:8];
      2'd2:    key_byte = key[7:0];
      default: key_byte = key[23:16];
    endcase
    j_ksa  = j + s_q + key_byte;
    j_prga = j + s_q;
  end

  // Every RAM-facing output is registered: a value assigned in a state is
  // presented to the RAM during the following state. The RAM then returns
  // data one cycle later. This is why each read is followed by a wait state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      key       <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      key_sel   <= '0;
      s_address <= '0;
      s_data    <= '0;
      s_wren    <= 1'b0;
      pt_ready  <= 1'b0;
      ct_data   <= '0;
      ct_valid  <= 1'b0;
      ct_index  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // sees the values from the start of the cycle. The write strobe and
      // pulses default low here and are raised only by the states that need them.
      start_q <= start;
      s_wren  <= 1'b0;
      s_data  <= '0;
      done    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start && !start_q) begin
            key   <= secret_key;
            i     <= '0;
            busy  <= 1'b1;
            state <= S_INIT;
          end
        end

        S_INIT: begin
          s_address <= i;
          s_data    <= i;
          s_wren    <= 1'b1;
          if (i == 8'hFF) begin
            i       <= '0;
            j       <= '0;
            key_sel <= '0;
            state   <= K_RD_I;
          end else begin
            i <= i + 8'd1;
          end
        end

        K_RD_I: begin
          s_address <= i;
          state     <= K_WT_I;
        end
        K_WT_I: state <= K_RD_J;
        K_RD_J: begin
          si        <= s_q;
          j         <= j_ksa;
          s_address <= j_ksa;
          state     <= K_WT_J;
        end
        K_WT_J: state <= K_WR_I;
        K_WR_I: begin
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state     <= K_WR_J;
        end
        K_WR_J: begin
          // When i == j the two writes land on the same cell with the same
          // value, so S is left unchanged without any special case.
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
          if (i == 8'hFF) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            state <= P_INC;
          end else begin
            i       <= i + 8'd1;
            key_sel <= (key_sel == 2'd2) ? 2'd0 : key_sel + 2'd1;
            state   <= K_RD_I;
          end
        end

        P_INC: begin
          i         <= i + 8'd1;
          s_address <= i + 8'd1;
          state     <= P_WT_I;
        end
        P_WT_I: state <= P_RD_J;
        P_RD_J: begin
          si        <= s_q;
          j         <= j_prga;
          s_address <= j_prga;
          state     <= P_WT_J;
        end
        P_WT_J: state <= P_WR_I;
        P_WR_I: begin
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state     <= P_WR_J;
        end
        P_WR_J: begin
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
          state     <= P_RD_F;
        end
        P_RD_F: begin
          s_address <= si + sj;
          state     <= P_WT_F;
        end
        P_WT_F: begin
          pt_ready <= 1'b1;
          state    <= P_PT;
        end
        P_PT: begin
          // The keystream address is held and nothing is written, so s_q
          // keeps returning f for as long as the plaintext wait lasts.
          if (pt_valid) begin
            ct_data  <= pt_data ^ s_q;
            ct_index <= k;
            pt_ready <= 1'b0;
            ct_valid <= 1'b1;
            state    <= P_OUT;
          end
        end
        P_OUT: begin
          if (ct_ready) begin
            ct_valid <= 1'b0;
            ct_data  <= '0;
            ct_index <= '0;
            if (k == LAST_K) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              s_address <= '0;
              state     <= S_DONE;
            end else begin
              k     <= k + 8'd1;
              state <= P_INC;
            end
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Directed testbench for rc4_encrypt_core (MSG_LEN = 9) with a behavioural
// 256x8 S RAM that uses a registered address.
module tb_rc4_encrypt_core;

  localparam int MSG_LEN = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  s_address, s_data, s_q;
  logic        s_wren;
  logic [7:0]  pt_data;
  logic        pt_valid, pt_ready;
  logic [7:0]  ct_data, ct_index;
  logic        ct_valid, ct_ready;
  logic        busy, done;

  always #10 clk = ~clk;

  rc4_encrypt_core #(.MSG_LEN(MSG_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .s_address  (s_address),
    .s_data     (s_data),
    .s_wren     (s_wren),
    .s_q        (s_q),
    .pt_data    (pt_data),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .ct_data    (ct_data),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready),
    .ct_index   (ct_index),
    .busy       (busy),
    .done       (done)
  );

  // S RAM: the address is registered, and read data appears the cycle after the address.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (s_wren) mem[s_address] <= s_data;
    s_q <= mem[s_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int overlap_cnt = 0;
  always @(negedge clk) if (pt_ready === 1'b1 && ct_valid === 1'b1) overlap_cnt++;

  logic [7:0] pt_vec [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct_vec [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [23:0] ksa_keys [3] = '{24'h000000, 24'hFFFFFF, 24'h3FFFFF};
  logic [7:0] model_s [256];

  int checks = 0;
  int passes = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic ksa_model(input logic [23:0] key);
    logic [7:0] jj, t;
    logic [7:0] kb [3];
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) model_s[n] = 8'(n);
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + model_s[n] + kb[n % 3];
      t = model_s[n];
      model_s[n] = model_s[jj];
      model_s[jj] = t;
    end
  endtask

  // Create a clean rising edge on start and record the cycle it is applied in.
  task automatic pulse_start();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
  endtask

  // Feed the plaintext vector and check the ciphertext stream, latency, spacing and done.
  task automatic run_vector(input int stall_byte);
    int         wait_n;
    int         last_hs;
    bit         stable;
    logic [7:0] held_d, held_i, held_a;
    ct_ready = 1'b1;
    pt_valid = 1'b1;
    pt_data  = pt_vec[0];
    wait_n = 0;
    while (pt_ready !== 1'b1 && wait_n < 4000) begin
      @(negedge clk);
      wait_n++;
    end
    check("first_pt_ready_latency", cyc - start_cyc, 1801);
    last_hs = 0;
    for (int b = 0; b < MSG_LEN; b++) begin
      pt_data = pt_vec[b];
      if (b == stall_byte) ct_ready = 1'b0;
      wait_n = 0;
      while (ct_valid !== 1'b1 && wait_n < 100) begin
        @(negedge clk);
        wait_n++;
      end
      check($sformatf("ct_data[%0d]", b), ct_data, ct_vec[b]);
      check($sformatf("ct_index[%0d]", b), ct_index, b);
      if (b == stall_byte) begin
        held_d = ct_data;
        held_i = ct_index;
        held_a = s_address;
        stable = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (ct_valid !== 1'b1 || ct_data !== held_d || ct_index !== held_i ||
              s_wren !== 1'b0 || s_address !== held_a || pt_ready !== 1'b0)
            stable = 1'b0;
        end
        check("backpressure_hold", stable, 1);
        ct_ready = 1'b1;
      end
      @(negedge clk);
      if (b > 0 && b != stall_byte) check($sformatf("byte_spacing[%0d]", b), cyc - last_hs, 10);
      last_hs = cyc;
    end
    check("done_pulse", done, 1);
    check("busy_low_in_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int wr_cnt;
    int bad;

    // NOTE: DUT inputs are driven with blocking assignments on the falling
    // edge, so they are stable before the next rising edge samples them.
    reset      = 1'b1;
    start      = 1'b0;
    secret_key = 24'h4B6579;
    pt_data    = 8'h00;
    pt_valid   = 1'b0;
    ct_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {s_address, s_data, s_wren, pt_ready, ct_data, ct_valid,
                            ct_index, busy, done}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Run A: known vector, with pt_valid and ct_ready tied high.
    pulse_start();
    repeat (3) @(negedge clk);
    check("busy_after_start", busy, 1);
    run_vector(-1);

    // start remains high across done, so no second run may start.
    wr_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (s_wren !== 1'b0 || busy !== 1'b0) wr_cnt++;
    end
    check("held_start_no_rerun", wr_cnt, 0);

    // Run B: a new start edge, an ignored edge while busy, and backpressure on byte 3.
    pulse_start();
    repeat (400) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    run_vector(3);
    wr_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (s_wren !== 1'b0 || busy !== 1'b0) wr_cnt++;
    end
    check("busy_edge_ignored", wr_cnt, 0);

    // Reset at cycle 1000 of a run, which falls mid-KSA.
    pt_valid = 1'b0;
    pulse_start();
    while (cyc - start_cyc < 1000) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", {s_address, s_data, s_wren, pt_ready, ct_data, ct_valid,
                                   ct_index, busy, done}, 0);
    reset = 1'b0;
    wr_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (s_wren !== 1'b0) wr_cnt++;
    end
    check("no_writes_after_reset", wr_cnt, 0);
    pulse_start();
    run_vector(-1);

    // Compare the S RAM contents after KSA against the reference schedule.
    pt_valid = 1'b0;
    for (int kk = 0; kk < 3; kk++) begin
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      secret_key = ksa_keys[kk];
      ksa_model(ksa_keys[kk]);
      pulse_start();
      while (cyc - start_cyc < 1796) @(negedge clk);
      bad = 0;
      for (int n = 0; n < 256; n++) if (mem[n] !== model_s[n]) bad++;
      check($sformatf("ksa_S_key_%06h", ksa_keys[kk]), bad, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    check("pt_ready_ct_valid_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rc4_encrypt_core.md
# rc4_encrypt_core

Single-core RC4 encryptor: the producer side of the brute-force key-search datapath. Given a 24-bit secret key, it initialises and schedules the S working RAM (KSA), runs the PRGA, and XORs a plaintext byte stream into a ciphertext byte stream. The bench and the ROM-image flow use it to generate encrypted messages that the `rc4_encapsulated` decryption cores must recover. It drives an external 256x8 `s_memory` instance; it contains no RAM of its own.

## Interface
Parameters:
- MSG_LEN, 32, number of bytes encrypted per run (1..256)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high
- start  in  1  level input (e.g. SW); a run begins on its rising edge
- secret_key  in  24  key; byte0 = [23:16], byte1 = [15:8], byte2 = [7:0]; latched at start
- s_address  out  8  S RAM address
- s_data  out  8  S RAM write data
- s_wren  out  1  S RAM write enable
- s_q  in  8  S RAM read data, valid the cycle after the address is applied
- pt_data  in  8  plaintext byte
- pt_valid  in  1  plaintext byte available
- pt_ready  out  1  core accepts plaintext this cycle
- ct_data  out  8  ciphertext byte
- ct_valid  out  1  ciphertext byte held
- ct_ready  in  1  downstream accepts ciphertext
- ct_index  out  8  index k of the byte on ct_data
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the last ciphertext handshake

## Operation
- Start detect: start_q registered each cycle. A run begins when start & ~start_q while in IDLE. It is ignored in any other state. Holding start high does not retrigger.
- IDLE: all outputs 0. On start-detect, latch key, i=0, go to INIT.
- INIT: one write per cycle, S[i]=i for i=0..255 (s_wren=1). After i=255, set i=j=0 and go to KSA.
- KSA, 6 states per iteration:
  - K_RD_I: address i.
  - K_WT_I.
  - K_RD_J: capture si, j=j+si+key[i mod 3] (mod 256), address j.
  - K_WT_J.
  - K_WR_I: capture sj, write S[i]=sj.
  - K_WR_J: write S[j]=si. If i=255, set i=j=k=0 and go to PRGA. Otherwise i++ and return to K_RD_I.
- PRGA, per byte:
  - P_INC: i=i+1, address i.
  - P_WT_I.
  - P_RD_J: capture si, j=j+si, address j.
  - P_WT_J.
  - P_WR_I: capture sj, write S[i]=sj.
  - P_WR_J: write S[j]=si.
  - P_RD_F: address si+sj (mod 256).
  - P_WT_F.
  - P_PT: capture f. pt_ready=1 while in this state. When pt_valid is seen, register ct_data=pt_data^f and ct_index=k, then go to P_OUT.
  - P_OUT: ct_valid=1, with ct_data and ct_index stable. When ct_ready is seen: if k=MSG_LEN-1, go to DONE; otherwise k++ and go to P_INC.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- i==j case: both swap writes occur; S is unchanged. This is correct by construction, with no special casing.
- All index arithmetic is 8-bit, wrapping mod 256. k is 8 bits.
- s_wren is high only in INIT, K_WR_*, and P_WR_*. s_data is don't-care otherwise but is driven to 0.

## Timing
- Reset: the state machine goes to IDLE. All outputs are 0 the cycle after reset is sampled: s_address, s_data, s_wren, pt_ready, ct_data, ct_valid, ct_index, busy, done. Also i=j=k=0 and start_q=0.
- Reset mid-run: abort immediately, no further RAM writes. S contents are undefined afterwards. A new start edge is required to run again.
- busy goes high the cycle after start-detect and stays high through P_OUT of the last byte. It is low during done.
- Latency from the start-detect edge:
  - INIT: 256 cycles.
  - KSA: 1536 cycles.
  - First pt_ready: 1801 cycles after the start-detect edge.
- Per-byte cost: 9 cycles plus pt wait plus (1 + ct_ready wait) cycles. The minimum is 10 cycles per byte.
- Handshakes:
  - pt_ready is never high at the same time as ct_valid.
  - ct_valid is held until ct_ready is seen, and never drops without a handshake.
  - pt_valid asserted early is harmless; it is only sampled in P_PT.

## Test plan
- Known vector: MSG_LEN=9, key 24'h4B6579 ("Key"), plaintext "Plaintext" (50 6C 61 69 6E 74 65 78 74). Required ciphertext: BB F3 16 E8 D9 40 AF 0A D3, with ct_index 0..8, followed by one done pulse.
- Timing check with pt_valid and ct_ready tied high: first pt_ready occurs exactly 1801 cycles after the start edge, and consecutive ct handshakes are 10 cycles apart.
- Backpressure: hold ct_ready low for 20 cycles on byte 3. ct_valid, ct_data and ct_index must stay stable, with no RAM activity. Ciphertext must be unchanged from the known vector.
- Reset at cycle 1000 (mid-KSA): all outputs 0 next cycle, and s_wren stays 0 afterwards. A new start edge then reproduces the known vector exactly.
- start held high across done: no second run. Toggling start low then high gives a second, identical run. A start edge while busy is ignored.
- Key-schedule model check: for keys 000000, FFFFFF and 3FFFFF, the final S RAM contents after KSA match the reference model byte-for-byte.
